// File: rtl/bram_stream_pkg.sv
// Shared definitions for the BRAM stream reader: read latency, skid FIFO depth and FSM encoding.
// Defining BRAM_REGOUT_EN selects the BRAM output-register configuration (RD_LAT=2, FIFO depth 5).
package bram_stream_pkg;

`ifdef BRAM_REGOUT_EN
  localparam int BRAM_RD_LAT            = 2;
  localparam int BRAM_STREAM_FIFO_DEPTH = 5;
`else
  localparam int BRAM_RD_LAT            = 1;
  localparam int BRAM_STREAM_FIFO_DEPTH = 4;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO with a registered output slot; a push into an empty FIFO is visible the next cycle.
// Output data and valid are held while the slot is full and the consumer stalls.
module stream_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] occupancy
);

  // The output slot holds one entry, so the backing store needs one fewer.
  localparam int MEM_DEPTH = DEPTH - 1;
  localparam int PTR_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [WIDTH-1:0] mem [MEM_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] mem_count;
  logic             slot_free, mem_empty, load_from_mem, bypass, mem_write;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MEM_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: every signal gets a value before any branch, so no latch can be inferred.
  always_comb begin
    slot_free     = !out_valid || out_ready;
    mem_empty     = (mem_count == '0);
    load_from_mem = slot_free && !mem_empty;
    bypass        = slot_free && mem_empty && push;
    mem_write     = push && !bypass;
  end

  // NOTE: sequential state uses non-blocking assignment so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
    end else begin
      if (load_from_mem) begin
        out_data  <= mem[rd_ptr];
        out_valid <= 1'b1;
        rd_ptr    <= ptr_inc(rd_ptr);
      end else if (bypass) begin
        out_data  <= push_data;
        out_valid <= 1'b1;
      end else if (slot_free) begin
        out_valid <= 1'b0;
      end
      if (mem_write) wr_ptr <= ptr_inc(wr_ptr);
      mem_count <= mem_count + CNT_W'(mem_write) - CNT_W'(load_from_mem);
    end
  end

  // NOTE: storage is not reset; pointers and counts alone define which entries are live.
  always_ff @(posedge clk) begin
    if (mem_write) mem[wr_ptr] <= push_data;
  end

  assign occupancy = mem_count + CNT_W'(out_valid);

endmodule

// File: rtl/bram_stream_reader.sv
// Sequential BRAM read master: issues credit-limited reads and streams the words out with m_last.
// Build with BRAM_REGOUT_EN defined when the BRAM output register is enabled.
module bram_stream_reader
  import bram_stream_pkg::*;
#(
  parameter int addr_width = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [addr_width-1:0] base_addr,
  input  logic [addr_width:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  bram_clken,
  output logic [addr_width-1:0] bram_addr,
  output logic [3:0]            bram_we,
  input  logic [31:0]           bram_data_out,
  output logic                  m_valid,
  output logic [31:0]           m_data,
  output logic                  m_last,
  input  logic                  m_ready
);

  localparam int RD_LAT = BRAM_RD_LAT;
  localparam int DEPTH  = BRAM_STREAM_FIFO_DEPTH;
  localparam int OCC_W  = $clog2(DEPTH + 1);
  localparam int OUT_W  = $clog2(DEPTH + RD_LAT + 2);
  localparam int CW     = addr_width + 1;

  state_e                state;
  logic [CW-1:0]         len_q, issued, delivered;
  logic [addr_width-1:0] next_addr;
  logic [RD_LAT:0]       pipe_vld, pipe_last;
  logic                  issue, issue_last, has_credit, pop, last_pop;
  logic [OCC_W-1:0]      occupancy;
  logic [OUT_W-1:0]      in_flight, outstanding;
  logic [32:0]           fifo_out;
  logic                  fifo_valid;

  assign bram_we  = 4'b0000;
  assign pop      = fifo_valid && m_ready;
  assign last_pop = pop && (delivered == len_q - CW'(1));

  // A slot freed by this cycle's handshake may be reused by this cycle's issue.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i <= RD_LAT; i++) in_flight = in_flight + OUT_W'(pipe_vld[i]);
    outstanding = in_flight + OUT_W'(occupancy);
    has_credit  = outstanding < (OUT_W'(DEPTH) + OUT_W'(pop));
  end

  always_comb begin
    issue      = 1'b0;
    issue_last = 1'b0;
    if (state == S_IDLE) begin
      issue      = start && (length != '0);
      issue_last = (length == CW'(1));
    end else if (state == S_RUN) begin
      issue      = (issued != len_q) && has_credit;
      issue_last = (issued == len_q - CW'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      bram_clken <= 1'b0;
      bram_addr  <= '0;
      next_addr  <= '0;
      len_q      <= '0;
      issued     <= '0;
      delivered  <= '0;
    end else begin
      done <= 1'b0;
      if (pop) delivered <= delivered + CW'(1);
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q     <= length;
            delivered <= '0;
            busy      <= 1'b1;
            if (length == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              // The first read is issued on the accepting edge itself.
              state      <= S_RUN;
              bram_clken <= 1'b1;
              bram_addr  <= base_addr;
              next_addr  <= base_addr + addr_width'(1);
              issued     <= CW'(1);
            end
          end
        end
        S_RUN: begin
          if (issue) begin
            bram_addr <= next_addr;
            next_addr <= next_addr + addr_width'(1);
            issued    <= issued + CW'(1);
          end
          if (issued == len_q) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (last_pop || (occupancy == '0 && in_flight == '0)) begin
            state      <= S_DONE;
            done       <= 1'b1;
            bram_clken <= 1'b0;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage 0 is the cycle the address is on the port; stage RD_LAT is the data cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld  <= '0;
      pipe_last <= '0;
    end else begin
      pipe_vld  <= {pipe_vld[RD_LAT-1:0], issue};
      pipe_last <= {pipe_last[RD_LAT-1:0], issue_last};
    end
  end

  stream_fifo #(
    .WIDTH (33),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pipe_vld[RD_LAT]),
    .push_data ({pipe_last[RD_LAT], bram_data_out}),
    .out_valid (fifo_valid),
    .out_data  (fifo_out),
    .out_ready (m_ready),
    .occupancy (occupancy)
  );

  assign m_valid = fifo_valid;
  assign m_data  = fifo_out[31:0];
  assign m_last  = fifo_valid && fifo_out[32];

endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench for bram_stream_reader: BRAM model returning word = address, scoreboard queue,
// cycle-accurate latency/done checks, random backpressure, mid-transfer reset and busy-start cases.
module tb_bram_stream_reader;
  import bram_stream_pkg::*;

  localparam int RD_LAT = BRAM_RD_LAT;
  localparam int DEPTH  = BRAM_STREAM_FIFO_DEPTH;

  logic        clk, rst_n, start;
  logic [11:0] base_addr;
  logic [12:0] length;
  logic        busy, done, bram_clken;
  logic [11:0] bram_addr;
  logic [3:0]  bram_we;
  logic [31:0] bram_data_out;
  logic        m_valid, m_last, m_ready;
  logic [31:0] m_data;

  int total = 0;
  int bad   = 0;
  logic [32:0] exp_q[$];
  int          words_seen = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] prev_data  = '0;
  logic        prev_last  = 1'b0;

  int          first_valid, last_c, done_c, done_cnt, max_occ;
  logic        busy_c1, busy_after, clken_seen, valid_seen;
  logic [11:0] addr_c1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: synchronous read, optional output register, both gated by the clock enable.
  logic [31:0] rd_q = '0;
  logic [31:0] rd_q2 = '0;
  always @(posedge clk) begin
    if (bram_clken) begin
      rd_q  <= 32'(bram_addr);
      rd_q2 <= rd_q;
    end
  end
`ifdef BRAM_REGOUT_EN
  assign bram_data_out = rd_q2;
`else
  assign bram_data_out = rd_q;
`endif

  bram_stream_reader #(.addr_width(12)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .base_addr     (base_addr),
    .length        (length),
    .busy          (busy),
    .done          (done),
    .bram_clken    (bram_clken),
    .bram_addr     (bram_addr),
    .bram_we       (bram_we),
    .bram_data_out (bram_data_out),
    .m_valid       (m_valid),
    .m_data        (m_data),
    .m_last        (m_last),
    .m_ready       (m_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_busy"}, 64'(busy), 64'd0);
    check({pfx, "_done"}, 64'(done), 64'd0);
    check({pfx, "_clken"}, 64'(bram_clken), 64'd0);
    check({pfx, "_addr"}, 64'(bram_addr), 64'd0);
    check({pfx, "_we"}, 64'(bram_we), 64'd0);
    check({pfx, "_valid"}, 64'(m_valid), 64'd0);
    check({pfx, "_data"}, 64'(m_data), 64'd0);
    check({pfx, "_last"}, 64'(m_last), 64'd0);
  endtask

  // Stream monitor: scoreboard compare on handshake, hold check after a stall.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev) begin
        check("hold_valid", 64'(m_valid), 64'd1);
        check("hold_data", 64'(m_data), 64'(prev_data));
        check("hold_last", 64'(m_last), 64'(prev_last));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_word", 64'(m_valid), 64'd0);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check("stream_data", 64'(m_data), 64'(e[31:0]));
          check("stream_last", 64'(m_last), 64'(e[32]));
          words_seen <= words_seen + 1;
        end
      end
      stall_prev <= m_valid && !m_ready;
      prev_data  <= m_data;
      prev_last  <= m_last;
    end else begin
      stall_prev <= 1'b0;
    end
  end

  // Queue the expected words, then drive start during cycle 0.
  task automatic do_start(input logic [11:0] base, input logic [12:0] len);
    for (int i = 0; i < int'(len); i++) begin
      logic [11:0] a;
      a = base + 12'(i);
      exp_q.push_back({(i == int'(len) - 1), 32'(a)});
    end
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = base;
    length    = len;
  endtask

  // Step through cycles 1..max after acceptance, recording timing events; stops one cycle after done.
  task automatic observe(input int max_cycles, input int rdy_pct, input int inject_at);
    first_valid = -1; last_c = -1; done_c = -1; done_cnt = 0; max_occ = 0;
    busy_c1 = 1'b0; busy_after = 1'b1; clken_seen = 1'b0; valid_seen = 1'b0; addr_c1 = '0;
    for (int c = 1; c <= max_cycles; c++) begin
      @(posedge clk); #1;
      m_ready = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < rdy_pct);
      if (c == inject_at) begin
        start = 1'b1; base_addr = 12'h7A0; length = 13'd2;
      end else begin
        start = 1'b0;
      end
      if (c == 1) begin busy_c1 = busy; addr_c1 = bram_addr; end
      if (m_valid && first_valid < 0) first_valid = c;
      if (m_valid && m_ready && m_last) last_c = c;
      if (done) begin done_cnt++; if (done_c < 0) done_c = c; end
      if (bram_clken) clken_seen = 1'b1;
      if (m_valid) valid_seen = 1'b1;
      if (int'(dut.u_fifo.occupancy) > max_occ) max_occ = int'(dut.u_fifo.occupancy);
      if (done_c > 0 && c == done_c + 1) begin busy_after = busy; break; end
    end
    check("xfer_completes", 64'(done_c > 0), 64'd1);
  endtask

  initial begin
    int w0;
    logic quiet;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;

    // Basic transfer: latency, back-to-back words, done one cycle after the last handshake.
    m_ready = 1'b1;
    do_start(12'h010, 13'd4);
    observe(40, 100, 0);
    check("t1_busy_c1", 64'(busy_c1), 64'd1);
    check("t1_addr_c1", 64'(addr_c1), 64'h010);
    check("t1_first_valid", 64'(first_valid), 64'(2 + RD_LAT));
    check("t1_no_bubbles", 64'(last_c), 64'(2 + RD_LAT + 3));
    check("t1_done_cycle", 64'(done_c), 64'(2 + RD_LAT + 4));
    check("t1_done_once", 64'(done_cnt), 64'd1);
    check("t1_busy_falls", 64'(busy_after), 64'd0);
    check("t1_drained", 64'(exp_q.size()), 64'd0);

    // Address wrap at the top of the BRAM.
    do_start(12'hFFE, 13'd4);
    observe(40, 100, 0);
    check("t2_addr_c1", 64'(addr_c1), 64'hFFE);
    check("t2_done_once", 64'(done_cnt), 64'd1);
    check("t2_drained", 64'(exp_q.size()), 64'd0);

    // Random backpressure, roughly 30% ready.
    w0 = words_seen;
    do_start(12'h300, 13'd16);
    observe(800, 30, 0);
    check("t3_word_count", 64'(words_seen - w0), 64'd16);
    check("t3_drained", 64'(exp_q.size()), 64'd0);
    check("t3_occ_bound", 64'(max_occ <= DEPTH), 64'd1);
    check("t3_done_once", 64'(done_cnt), 64'd1);

    // Zero-length command: done in cycle 1, no reads, no stream words.
    do_start(12'h055, 13'd0);
    observe(10, 100, 0);
    check("t4_done_cycle", 64'(done_c), 64'd1);
    check("t4_busy_c1", 64'(busy_c1), 64'd1);
    check("t4_busy_falls", 64'(busy_after), 64'd0);
    check("t4_no_clken", 64'(clken_seen), 64'd0);
    check("t4_no_valid", 64'(valid_seen), 64'd0);

    // Reset in the middle of a long transfer, then a fresh transfer from a new base.
    w0 = words_seen;
    m_ready = 1'b1;
    do_start(12'h100, 13'd32);
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (words_seen - w0 >= 5) break;
    end
    check("t5_reached_word5", 64'(words_seen - w0 >= 5), 64'd1);
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    check_idle_outputs("midrst");
    rst_n = 1'b1;
    do_start(12'h200, 13'd3);
    observe(40, 100, 0);
    check("t5_addr_c1", 64'(addr_c1), 64'h200);
    check("t5_first_valid", 64'(first_valid), 64'(2 + RD_LAT));
    check("t5_done_once", 64'(done_cnt), 64'd1);
    check("t5_drained", 64'(exp_q.size()), 64'd0);

    // A start pulse while busy must not disturb or follow the current transfer.
    w0 = words_seen;
    do_start(12'h020, 13'd6);
    observe(40, 100, 2);
    check("t6_word_count", 64'(words_seen - w0), 64'd6);
    check("t6_drained", 64'(exp_q.size()), 64'd0);
    check("t6_done_once", 64'(done_cnt), 64'd1);
    quiet = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (m_valid || busy) quiet = 1'b0;
    end
    check("t6_start_ignored", 64'(quiet), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
